// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MUL_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

    // pc_write_en, if_id_enable, id_ex_enable, if_id_flush, id_ex_bubble, stall_active
    localparam int unsigned CTRL_W = 6;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/stall_counter.sv
// Loadable down-counter with zero flag; sequences both MUL_WAIT and FLUSH.
module stall_counter
    import hazard_pkg::*;
#(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign cnt  = r_cnt;
    assign zero = (r_cnt == '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use / MUL-stall / branch-flush controller driving pipeline register enables.
// Optional stall statistics counters are built when STALL_STATS_EN is defined.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W   = 5,
    parameter int unsigned MUL_LAT      = 4,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  mul_start,
    input  logic                  branch_taken,
    output logic                  pc_write_en,
    output logic                  if_id_enable,
    output logic                  id_ex_enable,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble,
    output logic                  stall_active,
    output logic [1:0]            state_o,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           flush_count
);

    localparam int unsigned CNT_W = $clog2(max2(MUL_LAT, FLUSH_CYCLES) + 1);
    localparam logic [CNT_W-1:0] MUL_LOAD   = CNT_W'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_load_use;
    logic               w_cnt_load;
    logic [CNT_W-1:0]   w_cnt_load_val;
    logic               w_cnt_dec;
    logic               w_cnt_zero;
    logic [CNT_W-1:0]   w_cnt;
    logic               w_branch_acc;

    assign w_load_use = ex_mem_read && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));

    stall_counter #(.W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst      (reset),
        .load     (w_cnt_load),
        .load_val (w_cnt_load_val),
        .dec      (w_cnt_dec),
        .cnt      (w_cnt),
        .zero     (w_cnt_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_RUN;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_load     = 1'b0;
        w_cnt_load_val = '0;
        w_cnt_dec      = 1'b0;
        w_branch_acc   = 1'b0;
        pc_write_en    = 1'b1;
        if_id_enable   = 1'b1;
        id_ex_enable   = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_bubble   = 1'b0;
        stall_active   = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (branch_taken) begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    w_branch_acc = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        w_state_nxt    = ST_FLUSH;
                        w_cnt_load     = 1'b1;
                        w_cnt_load_val = FLUSH_LOAD;
                    end
                end else if (w_load_use) begin
                    pc_write_en  = 1'b0;
                    if_id_enable = 1'b0;
                    id_ex_bubble = 1'b1;
                    stall_active = 1'b1;
                end else if (mul_start && (MUL_LAT > 1)) begin
                    // The op enters EX this cycle; MUL_WAIT covers the remaining MUL_LAT-1.
                    w_state_nxt    = ST_MUL_WAIT;
                    w_cnt_load     = 1'b1;
                    w_cnt_load_val = MUL_LOAD;
                end
            end
            ST_MUL_WAIT: begin
                pc_write_en  = 1'b0;
                if_id_enable = 1'b0;
                id_ex_enable = 1'b0;
                stall_active = 1'b1;
                w_cnt_dec    = 1'b1;
                if (w_cnt_zero) w_state_nxt = ST_RUN;
            end
            ST_FLUSH: begin
                if_id_flush  = 1'b1;
                stall_active = 1'b1;
                w_cnt_dec    = 1'b1;
                if (w_cnt_zero) w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_RUN;
        endcase
        if (reset) begin
            pc_write_en  = 1'b0;
            if_id_enable = 1'b0;
            id_ex_enable = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            stall_active = 1'b0;
            w_branch_acc = 1'b0;
        end
    end

    assign state_o = r_state;

`ifdef STALL_STATS_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (stall_active && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + 32'd1;
            if (w_branch_acc && (r_flush_count  != '1)) r_flush_count  <= r_flush_count  + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule
